// File: rtl/psx_pkg.sv
// Shared PPB-side constants for the PSX controller protocol layer.
// Holds the protocol bytes, the responder FSM encoding and the pad snapshot layout.
package psx_pkg;

    localparam logic [7:0] PAD_ADDR   = 8'h01;
    localparam logic [7:0] POLL_CMD   = 8'h42;
    localparam logic [7:0] DIGITAL_ID = 8'h41;
    localparam logic [7:0] ANALOG_ID  = 8'h73;
    localparam logic [7:0] SYNC_BYTE  = 8'h5A;
    localparam logic [7:0] IDLE_REPLY = 8'hFF;

    localparam logic [1:0] ST_ADDR   = 2'd0;
    localparam logic [1:0] ST_CMD    = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_IGNORE = 2'd3;

    localparam logic [3:0] DIGITAL_PAYLOAD_LEN = 4'd2;
    localparam logic [3:0] ANALOG_PAYLOAD_LEN  = 4'd6;
    localparam logic [3:0] FIRST_PAYLOAD_IDX   = 4'd3;

    typedef struct packed {
        logic [15:0] buttons;
        logic [31:0] axes;     // {ly, lx, ry, rx}
        logic        analog;
    } pad_snapshot_t;

endpackage

// File: rtl/psx_pad_responder.sv
// Emulates a digital (0x41) or analog (0x73) pad answering the 0x01/0x42 poll on the PPB
// byte interface; pad state is captured on the address byte so each packet is coherent.
module psx_pad_responder
    import psx_pkg::*;
(
    input  logic        clk,
    input  logic        PPB_packet_reset,
    input  logic [7:0]  PPB_command,
    input  logic        PPB_command_strobe,
    input  logic        PPB_reply_ready,
    output logic [7:0]  PPB_reply,
    output logic        PPB_ack_strobe,
    input  logic [15:0] pad_buttons,
    input  logic [31:0] pad_axes,
    input  logic        pad_analog_mode,
    output logic        poll_done,
    output logic        protocol_error
);

    logic [1:0]    state_q, state_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    pad_snapshot_t snap_q, snap_d;
    logic [7:0]    reply_q, reply_d;
    logic          ack_q, ack_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ready_flag_q, ready_flag_d;
    logic          first_seen_q, first_seen_d;

    logic [7:0]    payload_byte;
    logic [3:0]    last_idx;

    // byte_idx names the reply byte being produced, so the packet ends when the
    // strobe arrives for the byte after the final payload reply.
    assign last_idx = FIRST_PAYLOAD_IDX +
                      (snap_q.analog ? ANALOG_PAYLOAD_LEN : DIGITAL_PAYLOAD_LEN);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        payload_byte = IDLE_REPLY;
        case (byte_idx_q)
            4'd3:    payload_byte = ~snap_q.buttons[7:0];
            4'd4:    payload_byte = ~snap_q.buttons[15:8];
            4'd5:    payload_byte = snap_q.axes[7:0];
            4'd6:    payload_byte = snap_q.axes[15:8];
            4'd7:    payload_byte = snap_q.axes[23:16];
            4'd8:    payload_byte = snap_q.axes[31:24];
            default: payload_byte = IDLE_REPLY;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        reply_d    = reply_q;
        ack_d      = 1'b0;
        done_d     = 1'b0;

        if (PPB_command_strobe) begin
            case (state_q)
                ST_ADDR: begin
                    if (PPB_command == PAD_ADDR) begin
                        snap_d  = '{buttons: pad_buttons, axes: pad_axes, analog: pad_analog_mode};
                        reply_d = pad_analog_mode ? ANALOG_ID : DIGITAL_ID;
                        ack_d   = 1'b1;
                        state_d = ST_CMD;
                    end else begin
                        reply_d = IDLE_REPLY;
                        state_d = ST_IGNORE;
                    end
                end
                ST_CMD: begin
                    if (PPB_command == POLL_CMD) begin
                        reply_d    = SYNC_BYTE;
                        ack_d      = 1'b1;
                        byte_idx_d = FIRST_PAYLOAD_IDX;
                        state_d    = ST_DATA;
                    end else begin
                        reply_d = IDLE_REPLY;
                        state_d = ST_IGNORE;
                    end
                end
                ST_DATA: begin
                    if (byte_idx_q == last_idx) begin
                        reply_d = IDLE_REPLY;
                        done_d  = 1'b1;
                        state_d = ST_IGNORE;
                    end else begin
                        reply_d    = payload_byte;
                        byte_idx_d = byte_idx_q + 4'd1;
                        ack_d      = 1'b1;
                    end
                end
                default: begin
                    reply_d = IDLE_REPLY;
                    state_d = ST_IGNORE;
                end
            endcase
        end
    end

    // A reply_ready landing on a strobe cycle belongs to the next byte, so set wins.
    always_comb begin
        first_seen_d = first_seen_q | PPB_command_strobe;
        err_d        = err_q | (PPB_command_strobe & ~ready_flag_q & first_seen_q);
        if (PPB_reply_ready)
            ready_flag_d = 1'b1;
        else if (PPB_command_strobe)
            ready_flag_d = 1'b0;
        else
            ready_flag_d = ready_flag_q;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            state_q      <= ST_ADDR;
            byte_idx_q   <= 4'd0;
            snap_q       <= '0;
            reply_q      <= IDLE_REPLY;
            ack_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ready_flag_q <= 1'b0;
            first_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            snap_q       <= snap_d;
            reply_q      <= reply_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ready_flag_q <= ready_flag_d;
            first_seen_q <= first_seen_d;
        end
    end

    assign PPB_reply      = reply_q;
    assign PPB_ack_strobe = ack_q;
    assign poll_done      = done_q;
    assign protocol_error = err_q;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Directed bench for psx_pad_responder: digital/analog polls, foreign address,
// unknown command, snapshot coherence, mid-packet reset and protocol error.
module tb_psx_pad_responder;

    logic        clk;
    logic        PPB_packet_reset;
    logic [7:0]  PPB_command;
    logic        PPB_command_strobe;
    logic        PPB_reply_ready;
    logic [7:0]  PPB_reply;
    logic        PPB_ack_strobe;
    logic [15:0] pad_buttons;
    logic [31:0] pad_axes;
    logic        pad_analog_mode;
    logic        poll_done;
    logic        protocol_error;

    int checks = 0;
    int errors = 0;

    psx_pad_responder dut (
        .clk                (clk),
        .PPB_packet_reset   (PPB_packet_reset),
        .PPB_command        (PPB_command),
        .PPB_command_strobe (PPB_command_strobe),
        .PPB_reply_ready    (PPB_reply_ready),
        .PPB_reply          (PPB_reply),
        .PPB_ack_strobe     (PPB_ack_strobe),
        .pad_buttons        (pad_buttons),
        .pad_axes           (pad_axes),
        .pad_analog_mode    (pad_analog_mode),
        .poll_done          (poll_done),
        .protocol_error     (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge.
    task automatic packet_reset();
        PPB_packet_reset = 1'b1;
        repeat (2) @(negedge clk);
        PPB_packet_reset = 1'b0;
        @(negedge clk);
    endtask

    // Checks the reply presented for this byte, strobes it, then checks the
    // ack/poll_done pulse one cycle later and that neither lingers.
    task automatic send_byte(input string tag, input logic [7:0] cmd, input logic [7:0] exp_reply,
                             input logic exp_ack, input logic exp_done, input logic give_ready);
        check({tag, ".reply"}, {24'd0, PPB_reply}, {24'd0, exp_reply});
        PPB_command        = cmd;
        PPB_command_strobe = 1'b1;
        @(negedge clk);
        PPB_command_strobe = 1'b0;
        check({tag, ".ack"}, {31'd0, PPB_ack_strobe}, {31'd0, exp_ack});
        check({tag, ".done"}, {31'd0, poll_done}, {31'd0, exp_done});
        @(negedge clk);
        check({tag, ".ack_off"}, {30'd0, PPB_ack_strobe, poll_done}, 32'd0);
        if (give_ready) begin
            PPB_reply_ready = 1'b1;
            @(negedge clk);
            PPB_reply_ready = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        PPB_packet_reset   = 1'b1;
        PPB_command        = 8'h00;
        PPB_command_strobe = 1'b0;
        PPB_reply_ready    = 1'b0;
        pad_buttons        = 16'h0009;
        pad_axes           = 32'h8080_8080;
        pad_analog_mode    = 1'b0;
        repeat (2) @(negedge clk);

        check("rst.reply", {24'd0, PPB_reply}, 32'h0000_00FF);
        check("rst.ack",   {31'd0, PPB_ack_strobe}, 32'd0);
        check("rst.done",  {31'd0, poll_done}, 32'd0);
        check("rst.err",   {31'd0, protocol_error}, 32'd0);
        PPB_packet_reset = 1'b0;
        @(negedge clk);

        // Digital poll: replies FF 41 5A F6 FF.
        send_byte("dig0", 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
        send_byte("dig1", 8'h42, 8'h41, 1'b1, 1'b0, 1'b1);
        send_byte("dig2", 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1);
        send_byte("dig3", 8'h00, 8'hF6, 1'b1, 1'b0, 1'b1);
        send_byte("dig4", 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        check("dig.tail_reply", {24'd0, PPB_reply}, 32'h0000_00FF);
        send_byte("dig5", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        check("dig.err", {31'd0, protocol_error}, 32'd0);
        packet_reset();

        // Analog poll: replies FF 73 5A FF FF 40 30 20 10.
        pad_buttons     = 16'h0000;
        pad_axes        = 32'h1020_3040;
        pad_analog_mode = 1'b1;
        send_byte("ana0", 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
        send_byte("ana1", 8'h42, 8'h73, 1'b1, 1'b0, 1'b1);
        send_byte("ana2", 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1);
        send_byte("ana3", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
        send_byte("ana4", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
        send_byte("ana5", 8'h00, 8'h40, 1'b1, 1'b0, 1'b1);
        send_byte("ana6", 8'h00, 8'h30, 1'b1, 1'b0, 1'b1);
        send_byte("ana7", 8'h00, 8'h20, 1'b1, 1'b0, 1'b1);
        send_byte("ana8", 8'h00, 8'h10, 1'b0, 1'b1, 1'b1);
        check("ana.tail_reply", {24'd0, PPB_reply}, 32'h0000_00FF);
        packet_reset();

        // Memory-card address: never participates.
        pad_analog_mode = 1'b0;
        send_byte("mc0", 8'h81, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_byte("mc1", 8'h42, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_byte("mc2", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_byte("mc3", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        check("mc.tail_reply", {24'd0, PPB_reply}, 32'h0000_00FF);
        packet_reset();

        // Unknown command after a valid address.
        send_byte("uc0", 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
        send_byte("uc1", 8'h43, 8'h41, 1'b0, 1'b0, 1'b1);
        send_byte("uc2", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_byte("uc3", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        packet_reset();

        // Buttons change mid-packet; replies must still reflect the 16'h1209 snapshot.
        pad_buttons = 16'h1209;
        send_byte("snap0", 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
        send_byte("snap1", 8'h42, 8'h41, 1'b1, 1'b0, 1'b1);
        pad_buttons     = 16'hFFFF;
        pad_analog_mode = 1'b1;
        send_byte("snap2", 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1);
        send_byte("snap3", 8'h00, 8'hF6, 1'b1, 1'b0, 1'b1);
        send_byte("snap4", 8'h00, 8'hED, 1'b0, 1'b1, 1'b1);
        packet_reset();

        // Reset lands right after the byte-1 strobe edge: ack and reply cleared at once.
        pad_buttons     = 16'h0009;
        pad_analog_mode = 1'b0;
        send_byte("ab0", 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
        PPB_command        = 8'h42;
        PPB_command_strobe = 1'b1;
        @(posedge clk);
        #1;
        PPB_packet_reset = 1'b1;
        #1;
        check("ab.reply", {24'd0, PPB_reply}, 32'h0000_00FF);
        check("ab.ack",   {31'd0, PPB_ack_strobe}, 32'd0);
        @(negedge clk);
        PPB_command_strobe = 1'b0;
        @(negedge clk);
        check("ab.hold_ack", {31'd0, PPB_ack_strobe}, 32'd0);
        PPB_packet_reset = 1'b0;
        @(negedge clk);

        // Next packet after the abort behaves normally.
        send_byte("nx0", 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
        send_byte("nx1", 8'h42, 8'h41, 1'b1, 1'b0, 1'b1);
        send_byte("nx2", 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1);
        send_byte("nx3", 8'h00, 8'hF6, 1'b1, 1'b0, 1'b1);
        send_byte("nx4", 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        check("nx.err", {31'd0, protocol_error}, 32'd0);
        packet_reset();

        // Bytes 1 and 2 strobed with no reply_ready between them.
        send_byte("pe0", 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
        check("pe.before", {31'd0, protocol_error}, 32'd0);
        send_byte("pe1", 8'h42, 8'h41, 1'b1, 1'b0, 1'b0);
        check("pe.still_ok", {31'd0, protocol_error}, 32'd0);
        send_byte("pe2", 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1);
        check("pe.set", {31'd0, protocol_error}, 32'd1);
        repeat (5) @(negedge clk);
        check("pe.sticky", {31'd0, protocol_error}, 32'd1);
        packet_reset();
        check("pe.cleared", {31'd0, protocol_error}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
